// File: rtl/regfile_commit_sink_pkg.sv
// rtl/regfile_commit_sink_pkg.sv - shared types and constants for the architectural register file
// Contents:
//   NUM_ARCH_REGS, ROB_IDX_W, ARCH_XLEN, ARCH_IDX_W : default geometry
//   rob_to_regfile   : ROB commit bus {valid, value, rob_idx, regfile_idx}
//   regfile_rd_port  : one read port result {value, busy, tag}
package regfile_commit_sink_pkg;

  localparam int NUM_ARCH_REGS = 32;
  localparam int ROB_IDX_W     = 5;
  localparam int ARCH_XLEN     = 32;
  localparam int ARCH_IDX_W    = $clog2(NUM_ARCH_REGS);

  typedef struct packed {
    logic                  valid;
    logic [ARCH_XLEN-1:0]  value;
    logic [ROB_IDX_W-1:0]  rob_idx;
    logic [ARCH_IDX_W-1:0] regfile_idx;
  } rob_to_regfile;

  typedef struct packed {
    logic [ARCH_XLEN-1:0] value;
    logic                 busy;
    logic [ROB_IDX_W-1:0] tag;
  } regfile_rd_port;

endpackage

// File: rtl/regfile_tag_table.sv
// rtl/regfile_tag_table.sv - rename status: per-register busy bit, owning ROB tag, busy count
// Ports:
//   clk, rst                                   : clock, synchronous active-low reset
//   commit_valid, commit_rob_idx, commit_rd    : commit bus (releases ownership on tag match)
//   issue_valid, issue_rd, issue_rob_idx       : dispatch rename of a destination
//   flush                                      : drops all in-flight ownership
//   busy, tag                                  : registered status arrays
//   busy_count                                 : registered popcount of busy
module regfile_tag_table #(
  parameter int NUM_REGS  = regfile_commit_sink_pkg::NUM_ARCH_REGS,
  parameter int ROB_IDX_W = regfile_commit_sink_pkg::ROB_IDX_W,
  localparam int IDX_W    = $clog2(NUM_REGS),
  localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                commit_valid,
  input  logic [ROB_IDX_W-1:0]                commit_rob_idx,
  input  logic [IDX_W-1:0]                    commit_rd,
  input  logic                                issue_valid,
  input  logic [IDX_W-1:0]                    issue_rd,
  input  logic [ROB_IDX_W-1:0]                issue_rob_idx,
  input  logic                                flush,
  output logic [NUM_REGS-1:0]                 busy,
  output logic [NUM_REGS-1:0][ROB_IDX_W-1:0]  tag,
  output logic [CNT_W-1:0]                    busy_count
);

  logic [NUM_REGS-1:0]                busy_nxt;
  logic [NUM_REGS-1:0][ROB_IDX_W-1:0] tag_nxt;
  logic [CNT_W-1:0]                   count_nxt;

  always_comb begin
    busy_nxt  = busy;
    tag_nxt   = tag;
    count_nxt = '0;
    // A commit only releases rd if it is still the owner; a younger issue keeps it.
    if (commit_valid && commit_rd != '0 && busy[commit_rd] && tag[commit_rd] == commit_rob_idx)
      busy_nxt[commit_rd] = 1'b0;
    // Issue is applied after the release so a same-cycle issue keeps rd busy.
    if (flush) begin
      busy_nxt = '0;
    end else if (issue_valid && issue_rd != '0) begin
      busy_nxt[issue_rd] = 1'b1;
      tag_nxt[issue_rd]  = issue_rob_idx;
    end
    for (int i = 0; i < NUM_REGS; i++)
      count_nxt = count_nxt + CNT_W'(busy_nxt[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      busy       <= '0;
      tag        <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      tag        <= tag_nxt;
      busy_count <= count_nxt;
    end
  end

endmodule

// File: rtl/regfile_commit_sink.sv
// rtl/regfile_commit_sink.sv - architectural register file fed by the ROB commit bus
// Optional feature macro: REGFILE_COMMIT_BYPASS_EN (forward the committing value to read ports)
// Ports:
//   clk, rst                                         : clock, synchronous active-low reset
//   commit_valid/value/rob_idx/regfile_idx           : ROB commit bus, one commit per cycle
//   issue_valid, issue_rd, issue_rob_idx             : dispatch rename of a destination
//   flush                                            : mispredict flush of all ownership
//   rs1_idx, rs2_idx                                 : read addresses
//   rs1/rs2_value, rs1/rs2_busy, rs1/rs2_tag         : combinational read results
//   busy_count                                       : number of busy registers
module regfile_commit_sink #(
  parameter int NUM_REGS  = regfile_commit_sink_pkg::NUM_ARCH_REGS,
  parameter int XLEN      = regfile_commit_sink_pkg::ARCH_XLEN,
  parameter int ROB_IDX_W = regfile_commit_sink_pkg::ROB_IDX_W,
  localparam int IDX_W    = $clog2(NUM_REGS),
  localparam int CNT_W    = $clog2(NUM_REGS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 commit_valid,
  input  logic [XLEN-1:0]      commit_value,
  input  logic [ROB_IDX_W-1:0] commit_rob_idx,
  input  logic [IDX_W-1:0]     commit_regfile_idx,
  input  logic                 issue_valid,
  input  logic [IDX_W-1:0]     issue_rd,
  input  logic [ROB_IDX_W-1:0] issue_rob_idx,
  input  logic                 flush,
  input  logic [IDX_W-1:0]     rs1_idx,
  input  logic [IDX_W-1:0]     rs2_idx,
  output logic [XLEN-1:0]      rs1_value,
  output logic [XLEN-1:0]      rs2_value,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [ROB_IDX_W-1:0] rs1_tag,
  output logic [ROB_IDX_W-1:0] rs2_tag,
  output logic [CNT_W-1:0]     busy_count
);

  import regfile_commit_sink_pkg::*;

  rob_to_regfile commit_bus;
  assign commit_bus = '{valid:       commit_valid,
                        value:       commit_value,
                        rob_idx:     commit_rob_idx,
                        regfile_idx: commit_regfile_idx};

  logic [NUM_REGS-1:0]                busy;
  logic [NUM_REGS-1:0][ROB_IDX_W-1:0] tag;

  regfile_tag_table #(
    .NUM_REGS  (NUM_REGS),
    .ROB_IDX_W (ROB_IDX_W)
  ) u_tag_table (
    .clk            (clk),
    .rst            (rst),
    .commit_valid   (commit_bus.valid),
    .commit_rob_idx (commit_bus.rob_idx),
    .commit_rd      (commit_bus.regfile_idx),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_rob_idx  (issue_rob_idx),
    .flush          (flush),
    .busy           (busy),
    .tag            (tag),
    .busy_count     (busy_count)
  );

  logic commit_wr;
  assign commit_wr = commit_bus.valid && commit_bus.regfile_idx != '0;

  // In-order commit makes every write architectural, regardless of ownership.
  // x0 is never written, so it holds its reset value of zero.
  logic [XLEN-1:0] regs [NUM_REGS];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (commit_wr) begin
      regs[commit_bus.regfile_idx] <= commit_bus.value;
    end
  end

  function automatic regfile_rd_port read_port(input logic [IDX_W-1:0] idx);
    regfile_rd_port p;
    p = '0;
    if (idx != '0) begin
      p.value = regs[idx];
      p.busy  = busy[idx];
      p.tag   = tag[idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (rst && commit_wr && idx == commit_bus.regfile_idx) begin
        p.value = commit_bus.value;
        if (busy[idx] && tag[idx] == commit_bus.rob_idx)
          p.busy = 1'b0;
      end
`endif
    end
    return p;
  endfunction

  regfile_rd_port rs1_port;
  regfile_rd_port rs2_port;

  always_comb begin
    rs1_port = read_port(rs1_idx);
    rs2_port = read_port(rs2_idx);
  end

  assign rs1_value = rs1_port.value;
  assign rs1_busy  = rs1_port.busy;
  assign rs1_tag   = rs1_port.tag;
  assign rs2_value = rs2_port.value;
  assign rs2_busy  = rs2_port.busy;
  assign rs2_tag   = rs2_port.tag;

endmodule

// File: tb/tb_regfile_commit_sink.sv
// tb/tb_regfile_commit_sink.sv - directed and randomized checks of regfile_commit_sink against a reference model
module tb_regfile_commit_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_value;
  logic [4:0]  commit_rob_idx;
  logic [4:0]  commit_regfile_idx;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic [4:0]  issue_rob_idx;
  logic        flush;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic        rs1_busy;
  logic        rs2_busy;
  logic [4:0]  rs1_tag;
  logic [4:0]  rs2_tag;
  logic [5:0]  busy_count;

  always #5 clk = ~clk;

  regfile_commit_sink dut (
    .clk                (clk),
    .rst                (rst),
    .commit_valid       (commit_valid),
    .commit_value       (commit_value),
    .commit_rob_idx     (commit_rob_idx),
    .commit_regfile_idx (commit_regfile_idx),
    .issue_valid        (issue_valid),
    .issue_rd           (issue_rd),
    .issue_rob_idx      (issue_rob_idx),
    .flush              (flush),
    .rs1_idx            (rs1_idx),
    .rs2_idx            (rs2_idx),
    .rs1_value          (rs1_value),
    .rs2_value          (rs2_value),
    .rs1_busy           (rs1_busy),
    .rs2_busy           (rs2_busy),
    .rs1_tag            (rs1_tag),
    .rs2_tag            (rs2_tag),
    .busy_count         (busy_count)
  );

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: architectural state as plain arrays.
  logic [31:0] m_val  [32];
  bit          m_busy [32];
  logic [4:0]  m_tag  [32];

  function automatic int model_count();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic exp_read(input logic [4:0] idx, output logic [31:0] v, output bit b, output logic [4:0] t);
    v = '0; b = 1'b0; t = '0;
    if (idx != 0) begin
      v = m_val[idx]; b = m_busy[idx]; t = m_tag[idx];
`ifdef REGFILE_COMMIT_BYPASS_EN
      if (rst && commit_valid && commit_regfile_idx == idx) begin
        v = commit_value;
        if (b && t == commit_rob_idx) b = 1'b0;
      end
`endif
    end
  endtask

  task automatic model_edge();
    bit owner;
    if (!rst) begin
      for (int i = 0; i < 32; i++) begin
        m_val[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else begin
      if (commit_valid && commit_regfile_idx != 0) begin
        owner = m_busy[commit_regfile_idx] && m_tag[commit_regfile_idx] == commit_rob_idx;
        m_val[commit_regfile_idx] = commit_value;
        if (owner) m_busy[commit_regfile_idx] = 1'b0;
      end
      if (flush) begin
        for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      end else if (issue_valid && issue_rd != 0) begin
        m_busy[issue_rd] = 1'b1;
        m_tag[issue_rd]  = issue_rob_idx;
      end
    end
  endtask

  task automatic check_reads();
    logic [31:0] v; bit b; logic [4:0] t;
    exp_read(rs1_idx, v, b, t);
    chk("rs1_value", rs1_value, v);
    chk("rs1_busy", rs1_busy, b);
    if (b) chk("rs1_tag", rs1_tag, t);
    exp_read(rs2_idx, v, b, t);
    chk("rs2_value", rs2_value, v);
    chk("rs2_busy", rs2_busy, b);
    if (b) chk("rs2_tag", rs2_tag, t);
    chk("busy_count", busy_count, model_count());
  endtask

  task automatic idle();
    commit_valid = 1'b0; commit_value = '0; commit_rob_idx = '0; commit_regfile_idx = '0;
    issue_valid = 1'b0; issue_rd = '0; issue_rob_idx = '0; flush = 1'b0;
  endtask

  // Inputs are set after a negedge; reads are checked before the posedge.
  task automatic step();
    #1 check_reads();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    idle();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin
      m_val[i] = 32'hx; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    rst = 1'b0; rs1_idx = '0; rs2_idx = '0;
    idle();
    @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);
    @(posedge clk); model_edge(); @(negedge clk);
    rst = 1'b1;

    for (int i = 1; i < 32; i++) begin
      rs1_idx = 5'(i); rs2_idx = 5'(32 - i);
      #1 chk("reset_value", rs1_value, 32'h0);
      chk("reset_busy", rs1_busy, 1'b0);
      chk("reset_count", busy_count, 6'd0);
      step();
    end

    issue_valid = 1; issue_rd = 5; issue_rob_idx = 3; step();
    commit_valid = 1; commit_value = 32'hDEADBEEF; commit_rob_idx = 3; commit_regfile_idx = 5; step();
    rs1_idx = 5;
    #1 chk("commit_value", rs1_value, 32'hDEADBEEF);
    chk("commit_busy", rs1_busy, 1'b0);
    chk("commit_count", busy_count, 6'd0);
    step();

    issue_valid = 1; issue_rd = 7; issue_rob_idx = 2; step();
    issue_valid = 1; issue_rd = 7; issue_rob_idx = 9; step();
    commit_valid = 1; commit_value = 32'h11; commit_rob_idx = 2; commit_regfile_idx = 7; step();
    rs1_idx = 7;
    #1 chk("stale_commit_value", rs1_value, 32'h11);
    chk("stale_commit_busy", rs1_busy, 1'b1);
    chk("stale_commit_tag", rs1_tag, 5'd9);
    commit_valid = 1; commit_value = 32'h22; commit_rob_idx = 9; commit_regfile_idx = 7; step();
    #1 chk("owner_commit_value", rs1_value, 32'h22);
    chk("owner_commit_busy", rs1_busy, 1'b0);
    step();

    issue_valid = 1; issue_rd = 8; issue_rob_idx = 4; step();
    commit_valid = 1; commit_value = 32'h55; commit_rob_idx = 4; commit_regfile_idx = 8;
    issue_valid = 1; issue_rd = 8; issue_rob_idx = 6; step();
    rs1_idx = 8;
    #1 chk("same_cycle_value", rs1_value, 32'h55);
    chk("same_cycle_busy", rs1_busy, 1'b1);
    chk("same_cycle_tag", rs1_tag, 5'd6);
    step();

    issue_valid = 1; issue_rd = 3;  issue_rob_idx = 10; step();
    issue_valid = 1; issue_rd = 4;  issue_rob_idx = 11; step();
    issue_valid = 1; issue_rd = 10; issue_rob_idx = 12; step();
    #1 chk("pre_flush_count", busy_count, 6'd4);
    flush = 1; issue_valid = 1; issue_rd = 12; issue_rob_idx = 1; step();
    rs1_idx = 12; rs2_idx = 7;
    #1 chk("flush_x12_busy", rs1_busy, 1'b0);
    chk("flush_count", busy_count, 6'd0);
    chk("flush_keeps_value", rs2_value, 32'h22);
    step();

    commit_valid = 1; commit_value = 32'hFFFFFFFF; commit_rob_idx = 0; commit_regfile_idx = 0;
    issue_valid = 1; issue_rd = 0; issue_rob_idx = 5; rs1_idx = 0; step();
    #1 chk("x0_value", rs1_value, 32'h0);
    chk("x0_busy", rs1_busy, 1'b0);
    chk("x0_count", busy_count, 6'd0);
    step();

    issue_valid = 1; issue_rd = 9; issue_rob_idx = 1; step();
    commit_valid = 1; commit_value = 32'h99; commit_rob_idx = 1; commit_regfile_idx = 9; rs1_idx = 9;
`ifdef REGFILE_COMMIT_BYPASS_EN
    #1 chk("bypass_value", rs1_value, 32'h99);
    chk("bypass_busy", rs1_busy, 1'b0);
`else
    #1 chk("no_bypass_value", rs1_value, 32'h0);
    chk("no_bypass_busy", rs1_busy, 1'b1);
`endif
    step();

    for (int n = 0; n < 800; n++) begin
      rst                = ($urandom_range(63) != 0);
      commit_valid       = 1'($urandom_range(1));
      commit_regfile_idx = 5'($urandom);
      commit_rob_idx     = ($urandom_range(1) == 0) ? m_tag[commit_regfile_idx] : 5'($urandom);
      commit_value       = $urandom;
      issue_valid        = ($urandom_range(9) < 4);
      issue_rd           = 5'($urandom);
      issue_rob_idx      = 5'($urandom);
      flush              = ($urandom_range(31) == 0);
      rs1_idx            = ($urandom_range(3) == 0) ? commit_regfile_idx : 5'($urandom);
      rs2_idx            = 5'($urandom);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_commit_sink.md
Name: regfile_commit_sink

Overview:
- Architectural register file on the receiving end of the ROB commit bus (valid, value, rob_idx, regfile_idx).
- Holds 32 x XLEN architectural values plus a per-register busy bit and ROB tag (rename status).
- Issue/dispatch marks a destination as owned by a ROB entry; commits write values and release ownership.
- Two combinational read ports feed dispatch/reservation stations with value, busy and tag.

Parameters:
- NUM_REGS, 32, architectural register count; index width $clog2(NUM_REGS).
- XLEN, 32, data width.
- ROB_IDX_W, 5, ROB index / tag width.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-low reset
- commit_valid  input  1  commit bus valid
- commit_value  input  XLEN  committed result
- commit_rob_idx  input  ROB_IDX_W  ROB entry committing
- commit_regfile_idx  input  5  destination register
- issue_valid  input  1  dispatch renames a destination this cycle
- issue_rd  input  5  destination being renamed
- issue_rob_idx  input  ROB_IDX_W  ROB entry allocated to issue_rd
- flush  input  1  mispredict flush; drops all in-flight ownership
- rs1_idx, rs2_idx  input  5 each  read addresses
- rs1_value, rs2_value  output  XLEN each  register value
- rs1_busy, rs2_busy  output  1 each  value pending in ROB
- rs1_tag, rs2_tag  output  ROB_IDX_W each  owning ROB entry; valid only when busy
- busy_count  output  6  number of busy registers

Behaviour:
- Reset (rst==0 at posedge): all values 0, busy 0, tags 0, busy_count 0. Read outputs are combinational, so they read 0 / not busy / tag 0 during and after reset. Reset overrides every other input in that cycle.
- Commit (commit_valid, rd!=0): the value is written at the posedge unconditionally; the ROB commits in order, so this is the architectural value.
  - If busy[rd] && tag[rd]==commit_rob_idx: busy is cleared.
  - If the tag mismatches (a younger issue owns rd): busy and tag are unchanged.
- Issue (issue_valid, rd!=0): at the posedge, busy[rd]=1 and tag[rd]=issue_rob_idx.
- Commit and issue to the same rd in one cycle: value written; busy stays 1; tag = issue_rob_idx (issue wins ownership).
- Flush: at the posedge, all busy bits clear. Values are retained. Issue in the same cycle is dropped. A commit in the same cycle still writes its value.
- x0: reads always return value 0, busy 0, tag 0. Commits and issues to x0 are ignored.
- No backpressure: a commit is accepted every cycle it is valid. Write latency is 1 cycle, visible at the read ports after the edge.
- busy_count: registered; equals the popcount of busy after each edge; range 0..31.
- Reads:
  - Same-cycle read of a register being issued returns the pre-issue state.
  - A read of a register being committed follows the feature below.

Optional Feature:
- REGFILE_COMMIT_BYPASS_EN defined: when commit_valid && rs_idx==commit_regfile_idx && rs_idx!=0, the read port forwards commit_value combinationally. busy reads 0 if the commit releases ownership (tag match).
- Not defined: reads see pre-edge state (old value, busy 1) and update the next cycle.

Decomposition:
- Shared package: reuse the existing rob_to_regfile struct for the commit bus (packed into the four commit_* ports at the instantiation site).
- Add to the package:
  - regfile_rd_port struct {value, busy, tag};
  - constants NUM_ARCH_REGS=32 and ROB_IDX_W=5.
- One natural sub-module, regfile_tag_table: busy/tag array, issue/commit/flush update logic, busy_count. It is instantiated once. The top module holds the value array and read muxing.

Test Plan:
- Reset: rst=0 two cycles, then read x1..x31 -> value 0, busy 0, busy_count 0.
- Issue rd=5 rob=3; next cycle commit {valid,value=0xDEADBEEF,rob=3,rd=5} -> after the edge rs1_idx=5 gives 0xDEADBEEF, busy 0, busy_count back to 0.
- Issue rd=7 rob=2, later issue rd=7 rob=9, then commit rob=2 rd=7 value=0x11 -> value 0x11, busy 1, tag 9; commit rob=9 value=0x22 -> value 0x22, busy 0.
- Same-cycle commit rob=4 rd=8 value=0x55 (owner tag 4) plus issue rd=8 rob=6 -> value 0x55, busy 1, tag 6.
- Busy x3, x4, x10, then flush with issue rd=12 rob=1 -> all busy 0, x12 not busy, values retained, busy_count 0.
- Commit rd=0 value=0xFFFFFFFF and issue rd=0 -> x0 reads 0, not busy. With REGFILE_COMMIT_BYPASS_EN, a same-cycle read of a committing rd=9 returns the new value with busy 0; without it, the old value with busy 1.
